uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_START = 3'd1;
  localparam logic [2:0] ENC_DATA  = 3'd2;
  localparam logic [2:0] ENC_STOP  = 3'd3;
  localparam logic [2:0] ENC_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ENC_IDLE,
    START = ENC_START,
    DATA  = ENC_DATA,
    STOP  = ENC_STOP,
    BREAK = ENC_BREAK
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, baud tick and received-byte outputs of the UART receiver.
interface uart_rx_if #(
  parameter int DB = 8
) ();
  logic          rx;
  logic          s_tick;
  logic [DB-1:0] d_out;
  logic          rx_done;
  logic          frame_err;

  // master: the line/baud side driving the receiver; slave: the receiver itself
  modport master (
    output rx, s_tick,
    input  d_out, rx_done, frame_err
  );

  modport slave (
    input  rx, s_tick,
    output d_out, rx_done, frame_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop recovery, LSB first, with
// frame-error detection and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DB      = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int         NW         = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [4:0] S_MID      = 5'(MID_START);
  localparam logic [4:0] S_BIT_END  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DB - 1);

  logic rx_s;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [4:0]    s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [DB-1:0] b_q, b_d;
  logic [DB-1:0] dout_q, dout_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Reacts to the line without waiting for a tick, so back-to-back frames work.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = {rx_s, b_q[DB-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP_END) begin
            if (rx_s) begin
              dout_d    = b_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a break reports only once.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.d_out     = dout_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, back-to-back, glitch, frame error, break, reset.
module tb_uart_rx;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   tick_cnt;

  int       done_cnt;
  int       ferr_cnt;
  int       both_cnt;
  logic [7:0] data_log [0:15];

  uart_rx_if #(.DB(8)) bus ();

  uart_rx #(.DB(8), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk baud tick every 10 clocks, changed on the falling edge.
  initial begin
    bus.s_tick = 1'b0;
    tick_cnt   = 0;
    forever begin
      @(negedge clk);
      tick_cnt   = (tick_cnt == 9) ? 0 : tick_cnt + 1;
      bus.s_tick = (tick_cnt == 9);
    end
  end

  always @(negedge clk) begin
    if (bus.rx_done) begin
      data_log[done_cnt[3:0]] <= bus.d_out;
      done_cnt <= done_cnt + 1;
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.rx_done && bus.frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
    $display("[TB] %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      wait_ticks(16);
    end
    bus.rx = stop_val;
    wait_ticks(16);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    ferr_cnt = 0;
    both_cnt = 0;
    bus.rx   = 1'b1;
    reset    = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_d_out", 32'(bus.d_out), 32'h00);
    check("reset_rx_done", 32'(bus.rx_done), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);

    wait_ticks(4);
    send_frame(8'h55, 1'b1);
    wait_ticks(8);
    check("f55_done_cnt", 32'(done_cnt), 32'd1);
    check("f55_data", 32'(data_log[0]), 32'h55);
    check("f55_d_out", 32'(bus.d_out), 32'h55);
    check("f55_ferr_cnt", 32'(ferr_cnt), 32'd0);

    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_ticks(8);
    check("b2b_done_cnt", 32'(done_cnt), 32'd3);
    check("b2b_first", 32'(data_log[1]), 32'hA3);
    check("b2b_second", 32'(data_log[2]), 32'h0F);
    check("b2b_d_out", 32'(bus.d_out), 32'h0F);

    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(12);
    check("glitch_done_cnt", 32'(done_cnt), 32'd3);
    check("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("glitch_d_out", 32'(bus.d_out), 32'h0F);

    send_frame(8'h3C, 1'b0);
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(16);
    check("ferr_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("ferr_done_cnt", 32'(done_cnt), 32'd3);
    check("ferr_d_out", 32'(bus.d_out), 32'h0F);
    send_frame(8'h81, 1'b1);
    wait_ticks(8);
    check("after_ferr_done_cnt", 32'(done_cnt), 32'd4);
    check("after_ferr_d_out", 32'(bus.d_out), 32'h81);

    bus.rx = 1'b0;
    wait_ticks(480);
    bus.rx = 1'b1;
    wait_ticks(16);
    check("break_ferr_cnt", 32'(ferr_cnt), 32'd2);
    check("break_done_cnt", 32'(done_cnt), 32'd4);
    send_frame(8'h7E, 1'b1);
    wait_ticks(8);
    check("after_break_done_cnt", 32'(done_cnt), 32'd5);
    check("after_break_d_out", 32'(bus.d_out), 32'h7E);

    // 0xFF frame interrupted by reset in the middle of data bit 4.
    bus.rx = 1'b0;
    wait_ticks(16);
    bus.rx = 1'b1;
    wait_ticks(64 + 8);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_d_out", 32'(bus.d_out), 32'h00);
    wait_ticks(8 + 48 + 16 + 8);
    check("midreset_done_cnt", 32'(done_cnt), 32'd5);
    check("midreset_ferr_cnt", 32'(ferr_cnt), 32'd2);
    check("midreset_d_out_hold", 32'(bus.d_out), 32'h00);
    send_frame(8'h12, 1'b1);
    wait_ticks(8);
    check("after_reset_done_cnt", 32'(done_cnt), 32'd6);
    check("after_reset_d_out", 32'(bus.d_out), 32'h12);
    check("after_reset_log", 32'(data_log[5]), 32'h12);
    check("no_simultaneous_pulses", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
